// File: rtl/cp0_exception_unit_pkg.sv
// Shared CP0 constants: register numbers, exception codes and the Status reset value.
package cp0_exception_unit_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned WORD  = 32;
    localparam int unsigned EXC_W = 5;

    localparam logic [4:0] STATUS_REGISTER    = 5'd12;
    localparam logic [4:0] CAUSE_REGISTER     = 5'd13;
    localparam logic [4:0] EPC_REGISTER       = 5'd14;
    localparam logic [4:0] BAD_INSTR_REGISTER = 5'd8;

    localparam logic [EXC_W-1:0] EXC_NONE = 5'h00;
    localparam logic [EXC_W-1:0] EXC_OV   = 5'h0C;
    localparam logic [EXC_W-1:0] EXC_RI   = 5'h0A;
    localparam logic [EXC_W-1:0] EXC_SYS  = 5'h08;
    localparam logic [EXC_W-1:0] EXC_BP   = 5'h09;

    localparam logic [WORD-1:0] STATUS_RESET = 32'h0000_FF01;

    // Fixed-priority exception encoder: overflow > reserved inst > syscall > break.
    function automatic logic [EXC_W-1:0] next_exc_code(input logic ov, input logic ri,
                                                      input logic sys, input logic bp);
        if (ov)       return EXC_OV;
        else if (ri)  return EXC_RI;
        else if (sys) return EXC_SYS;
        else if (bp)  return EXC_BP;
        else          return EXC_NONE;
    endfunction

endpackage

// File: rtl/cp0_exception_unit_if.sv
// Pipeline-side CP0 bus: MFC0/MTC0/ERET traffic, exception requests and handler redirect.
interface cp0_exception_unit_if;
    import cp0_exception_unit_pkg::*;

    logic [XLEN-1:0] rd_data;
    logic [XLEN-1:0] EPC;
    logic            takenHandler;
    logic [XLEN-1:0] wr_data;
    logic [4:0]      regnum;
    logic [2:0]      sel;
    logic [XLEN-1:0] curr_pc;
    logic            MTC0;
    logic            ERET;
    logic [7:0]      interrupt_source;
    logic            overflow;
    logic            reserved_inst;
    logic            syscall;
    logic            break_;

    modport slave (
        input  wr_data, regnum, sel, curr_pc, MTC0, ERET, interrupt_source,
               overflow, reserved_inst, syscall, break_,
        output rd_data, EPC, takenHandler
    );

    modport master (
        output wr_data, regnum, sel, curr_pc, MTC0, ERET, interrupt_source,
               overflow, reserved_inst, syscall, break_,
        input  rd_data, EPC, takenHandler
    );
endinterface

// File: rtl/cp0_exception_unit_mux3v.sv
// Three-input mux; select value 3 yields zero.
module cp0_exception_unit_mux3v #(
    parameter int unsigned W = 64
) (
    input  logic [1:0]   sel_i,
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    input  logic [W-1:0] d2_i,
    output logic [W-1:0] y_o
);
    always_comb begin
        y_o = '0;
        case (sel_i)
            2'd0:    y_o = d0_i;
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            default: y_o = '0;
        endcase
    end
endmodule

// File: rtl/cp0_exception_unit_register.sv
// Enabled register with parameterised width and reset value.
module cp0_exception_unit_register #(
    parameter int unsigned    W         = 1,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    q_o <= RESET_VAL;
        else if (en_i) q_o <= d_i;
    end
endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 exception/interrupt controller: Status, Cause, EPC and BadInstr with handler redirect.
module cp0_exception_unit
    import cp0_exception_unit_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    cp0_exception_unit_if.slave  bus
);
    logic [WORD-1:0]  user_status_q, bad_instr_q;
    logic             exl_q, exl_d, exl_en;
    logic [XLEN-1:0]  epc_q, epc_d;
    logic [EXC_W-1:0] exc_code_q, exc_code_d, exc_code_nxt;
    logic [WORD-1:0]  status, cause, bad_instr_d;
    logic             taken_exception, taken_interrupt, taken_handler;
    logic             mtc0_status, mtc0_epc, epc_en, bad_en, exc_en;
    logic [1:0]       epc_sel;

    assign exc_code_nxt    = next_exc_code(bus.overflow, bus.reserved_inst, bus.syscall, bus.break_);
    assign taken_exception = (exc_code_nxt != EXC_NONE);

    assign status = {user_status_q[31:3], user_status_q[2], exl_q, user_status_q[0]};
    assign cause  = {16'b0, bus.interrupt_source, 1'b0, exc_code_q, 2'b0};

    // Interrupts are held off while an exception code is still latched or ERL is set.
    assign taken_interrupt = (|(cause[15:8] & status[15:8])) && (exc_code_q == EXC_NONE)
                             && status[0] && !status[2];
    assign taken_handler   = (taken_interrupt || taken_exception) && !exl_q;

    assign mtc0_status = bus.MTC0 && (bus.regnum == STATUS_REGISTER) && (bus.sel == 3'd0);
    assign mtc0_epc    = bus.MTC0 && (bus.regnum == EPC_REGISTER)    && (bus.sel == 3'd0);

    // Priority ERET > handler > MTC0.
    assign exl_en = bus.ERET || taken_handler || mtc0_status;
    assign exl_d  = bus.ERET ? 1'b0 : (taken_handler ? 1'b1 : bus.wr_data[1]);

    assign epc_en  = taken_handler || mtc0_epc;
    assign epc_sel = taken_handler ? (taken_exception ? 2'd2 : 2'd1) : 2'd0;

    assign bad_en      = bus.ERET || taken_exception;
    assign bad_instr_d = bus.ERET ? '0 : bus.wr_data[WORD-1:0];

    assign exc_en     = taken_handler || bus.ERET;
    assign exc_code_d = taken_handler ? exc_code_nxt : EXC_NONE;

    cp0_exception_unit_register #(.W(WORD), .RESET_VAL(STATUS_RESET)) u_user_status (
        .clk(clock), .rst_n(reset), .en_i(mtc0_status), .d_i(bus.wr_data[WORD-1:0]), .q_o(user_status_q)
    );

    cp0_exception_unit_register #(.W(1), .RESET_VAL(1'b0)) u_exl (
        .clk(clock), .rst_n(reset), .en_i(exl_en), .d_i(exl_d), .q_o(exl_q)
    );

    cp0_exception_unit_mux3v #(.W(XLEN)) u_epc_mux (
        .sel_i(epc_sel), .d0_i(bus.wr_data), .d1_i(bus.curr_pc),
        .d2_i(bus.curr_pc + XLEN'(4)), .y_o(epc_d)
    );

    cp0_exception_unit_register #(.W(XLEN), .RESET_VAL('0)) u_epc (
        .clk(clock), .rst_n(reset), .en_i(epc_en), .d_i(epc_d), .q_o(epc_q)
    );

    cp0_exception_unit_register #(.W(WORD), .RESET_VAL('0)) u_bad_instr (
        .clk(clock), .rst_n(reset), .en_i(bad_en), .d_i(bad_instr_d), .q_o(bad_instr_q)
    );

    cp0_exception_unit_register #(.W(EXC_W), .RESET_VAL(EXC_NONE)) u_exc_code (
        .clk(clock), .rst_n(reset), .en_i(exc_en), .d_i(exc_code_d), .q_o(exc_code_q)
    );

    // MFC0 read decode on {regnum, sel}.
    always_comb begin
        bus.rd_data = '0;
        case ({bus.regnum, bus.sel})
            {STATUS_REGISTER, 3'd0}:    bus.rd_data = {32'b0, status};
            {CAUSE_REGISTER, 3'd0}:     bus.rd_data = {32'b0, cause};
            {EPC_REGISTER, 3'd0}:       bus.rd_data = epc_q;
            {BAD_INSTR_REGISTER, 3'd1}: bus.rd_data = {32'b0, bad_instr_q};
            default:                    bus.rd_data = '0;
        endcase
    end

    assign bus.EPC          = epc_q;
    assign bus.takenHandler = taken_handler;
endmodule

// File: tb/tb_cp0_exception_unit.sv
// Scoreboard bench for cp0_exception_unit: expected CP0 reads queued with stimulus, drained after the edge.
module tb_cp0_exception_unit;
    import cp0_exception_unit_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #10 clock = ~clock;

    cp0_exception_unit_if bus();

    cp0_exception_unit dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        string       tag;
        logic [4:0]  rn;
        logic [2:0]  sl;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic expect_rd(input string tag, input logic [4:0] rn, input logic [2:0] sl,
                             input logic [63:0] val);
        exp_t e;
        e.tag = tag; e.rn = rn; e.sl = sl; e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        bus.wr_data = '0; bus.regnum = '0; bus.sel = '0; bus.curr_pc = '0;
        bus.MTC0 = 1'b0; bus.ERET = 1'b0; bus.interrupt_source = '0;
        bus.overflow = 1'b0; bus.reserved_inst = 1'b0; bus.syscall = 1'b0; bus.break_ = 1'b0;
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            bus.regnum = e.rn;
            bus.sel    = e.sl;
            #1;
            check(e.tag, bus.rd_data, e.val);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
        drain();
        @(negedge clock);
    endtask

    task automatic chk_th(input string tag, input logic exp);
        #1;
        check(tag, 64'(bus.takenHandler), 64'(exp));
    endtask

    initial begin
        idle();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        expect_rd("rst_status", STATUS_REGISTER, 3'd0, 64'h0000_FF01);
        expect_rd("rst_cause",  CAUSE_REGISTER,  3'd0, 64'h0);
        expect_rd("rst_epc",    EPC_REGISTER,    3'd0, 64'h0);
        expect_rd("rst_bad",    BAD_INSTR_REGISTER, 3'd1, 64'h0);
        drain();
        chk_th("rst_th", 1'b0);
        @(negedge clock);

        bus.syscall = 1'b1; bus.curr_pc = 64'h1000; bus.wr_data = 64'hDEAD_BEEF;
        chk_th("sys_th", 1'b1);
        expect_rd("sys_epc",    EPC_REGISTER,    3'd0, 64'h1004);
        expect_rd("sys_cause",  CAUSE_REGISTER,  3'd0, 64'h20);
        expect_rd("sys_status", STATUS_REGISTER, 3'd0, 64'h0000_FF03);
        expect_rd("sys_bad",    BAD_INSTR_REGISTER, 3'd1, 64'hDEAD_BEEF);
        step();

        bus.syscall = 1'b1; bus.curr_pc = 64'h3000; bus.wr_data = 64'h55;
        chk_th("exl_th", 1'b0);
        expect_rd("exl_epc",   EPC_REGISTER,   3'd0, 64'h1004);
        expect_rd("exl_bad",   BAD_INSTR_REGISTER, 3'd1, 64'h55);
        expect_rd("exl_cause", CAUSE_REGISTER, 3'd0, 64'h20);
        step();

        bus.ERET = 1'b1;
        expect_rd("eret_status", STATUS_REGISTER, 3'd0, 64'h0000_FF01);
        expect_rd("eret_cause",  CAUSE_REGISTER,  3'd0, 64'h0);
        expect_rd("eret_bad",    BAD_INSTR_REGISTER, 3'd1, 64'h0);
        expect_rd("eret_epc",    EPC_REGISTER,    3'd0, 64'h1004);
        step();

        bus.overflow = 1'b1; bus.break_ = 1'b1; bus.curr_pc = 64'h4000;
        chk_th("ov_th", 1'b1);
        expect_rd("ov_cause", CAUSE_REGISTER, 3'd0, 64'h30);
        expect_rd("ov_epc",   EPC_REGISTER,   3'd0, 64'h4004);
        step();
        bus.ERET = 1'b1;
        expect_rd("ov_eret_cause", CAUSE_REGISTER, 3'd0, 64'h0);
        step();

        bus.interrupt_source = 8'h04; bus.curr_pc = 64'h2000;
        bus.regnum = CAUSE_REGISTER; bus.sel = 3'd0;
        chk_th("irq_th", 1'b1);
        check("irq_cause_live", bus.rd_data, 64'h0400);
        expect_rd("irq_epc",    EPC_REGISTER,    3'd0, 64'h2000);
        expect_rd("irq_status", STATUS_REGISTER, 3'd0, 64'h0000_FF03);
        expect_rd("irq_cause",  CAUSE_REGISTER,  3'd0, 64'h0);
        step();
        check("irq_epc_port", bus.EPC, 64'h2000);
        bus.ERET = 1'b1;
        step();

        bus.MTC0 = 1'b1; bus.regnum = STATUS_REGISTER; bus.sel = 3'd0; bus.wr_data = 64'h0000_FB01;
        expect_rd("mask_status", STATUS_REGISTER, 3'd0, 64'h0000_FB01);
        step();
        bus.interrupt_source = 8'h04;
        chk_th("masked_irq_th", 1'b0);
        bus.interrupt_source = 8'h08;
        chk_th("unmasked_irq_th", 1'b1);
        idle();

        bus.MTC0 = 1'b1; bus.regnum = EPC_REGISTER; bus.sel = 3'd0; bus.wr_data = 64'h1234;
        expect_rd("mtc0_epc", EPC_REGISTER, 3'd0, 64'h1234);
        step();

        bus.MTC0 = 1'b1; bus.regnum = STATUS_REGISTER; bus.sel = 3'd0; bus.wr_data = 64'h2;
        expect_rd("mtc0_status", STATUS_REGISTER, 3'd0, 64'h2);
        step();
        bus.syscall = 1'b1;
        chk_th("blocked_sys_th", 1'b0);
        bus.syscall = 1'b0; bus.interrupt_source = 8'hFF;
        chk_th("blocked_irq_th", 1'b0);
        idle();
        expect_rd("rd_unmapped",  5'd5,  3'd0, 64'h0);
        expect_rd("rd_bad_sel0",  BAD_INSTR_REGISTER, 3'd0, 64'h0);
        expect_rd("rd_status_s1", STATUS_REGISTER, 3'd1, 64'h0);
        drain();
        @(negedge clock);

        bus.ERET = 1'b1;
        expect_rd("eret2_status", STATUS_REGISTER, 3'd0, 64'h0);
        step();
        bus.syscall = 1'b1; bus.curr_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        chk_th("wrap_th", 1'b1);
        expect_rd("wrap_epc", EPC_REGISTER, 3'd0, 64'h0);
        step();

        bus.MTC0 = 1'b1; bus.regnum = STATUS_REGISTER; bus.sel = 3'd0; bus.wr_data = 64'h2;
        #2 reset = 1'b0;
        #1;
        check("async_rst_status", bus.rd_data, 64'h0000_FF01);
        check("async_rst_epc",    bus.EPC,     64'h0);
        @(posedge clock);
        #1;
        check("held_rst_status", bus.rd_data, 64'h0000_FF01);
        idle();
        @(negedge clock);
        reset = 1'b1;
        expect_rd("post_rst_status", STATUS_REGISTER, 3'd0, 64'h0000_FF01);
        expect_rd("post_rst_bad",    BAD_INSTR_REGISTER, 3'd1, 64'h0);
        expect_rd("post_rst_cause",  CAUSE_REGISTER, 3'd0, 64'h0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cp0_exception_unit.md
Name: cp0_exception_unit

Overview:
Coprocessor-0 exception/interrupt controller for the 64-bit MIPS pipeline. It holds the Status, Cause, EPC and BadInstr registers and prioritises synchronous exceptions (overflow, reserved instruction, syscall, break) and external interrupts. It raises a combinational handler-taken signal, serves MFC0/MTC0/ERET traffic, and sits beside the execute stage, feeding EPC and takenHandler to PC selection.

Parameters:
STATUS_REGISTER, 5'd12, CP0 regnum of Status
CAUSE_REGISTER, 5'd13, CP0 regnum of Cause
EPC_REGISTER, 5'd14, CP0 regnum of EPC
BAD_INSTR_REGISTER, 5'd8, CP0 regnum of BadInstr (read at sel=1)

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-low (asserted at 0)
rd_data  out  64  MFC0 read data (combinational)
EPC  out  64  exception return PC
takenHandler  out  1  combinational: redirect to handler this cycle
wr_data  in  64  MTC0 data / BadInstr capture value
regnum  in  5  CP0 register number
sel  in  3  CP0 select field
curr_pc  in  64  PC of the instruction in the stage
MTC0  in  1  write strobe
ERET  in  1  exception return strobe
interrupt_source  in  8  external interrupt lines (level)
overflow, reserved_inst, syscall, break_  in  1 each  exception requests

Behaviour:
- Reset values: user_status=32'h0000_FF01 (IM all 1s, IE=1); EXL=0; exc_code=0; EPC=0; BadInstr=0.
- next_exc_code (fixed priority): overflow 5'h0C > reserved_inst 5'h0A > syscall 5'h08 > break_ 5'h09 > none 5'h00.
- takenException = next_exc_code != 0.
- status = {user_status[31:3], user_status[2] (ERL), EXL, user_status[0] (IE)}.
- cause = {16'b0, interrupt_source, 1'b0, exc_code, 2'b0}.
- takenInterrupt = |(cause[15:8] & status[15:8]) && exc_code==0 && IE && !ERL.
- takenHandler = (takenInterrupt || takenException) && !EXL. Same-cycle combinational output.
- user_status: loads wr_data[31:0] when MTC0 && regnum==STATUS_REGISTER && sel==0.
- EXL register:
  - ERET clears it synchronously.
  - Otherwise takenHandler sets it to 1.
  - Otherwise an MTC0 to Status (sel 0) loads wr_data[1].
  - Priority: ERET > handler > MTC0.
- EPC register:
  - If takenHandler, loads curr_pc+4 when takenException, else curr_pc. Exception wins when both are pending.
  - Otherwise an MTC0 to EPC_REGISTER with sel 0 loads wr_data.
  - Addition wraps modulo 2^64.
- BadInstr register:
  - Loads wr_data[31:0] whenever takenException, independent of EXL.
  - ERET clears it synchronously; ERET has priority.
- exc_code register: loads next_exc_code on takenHandler; else ERET clears it to 0; else it holds.
- rd_data decode on {regnum,sel}:
  - Status/0 -> {32'b0,status}
  - Cause/0 -> {32'b0,cause}
  - EPC/0 -> EPC
  - BadInstr/1 -> {32'b0,BadInstr}
  - Any other pair -> 64'b0.
- Reset asserted mid-operation forces all registers to reset values immediately, regardless of MTC0/ERET/handler activity.
- While EXL=1, exceptions and interrupts are not taken (takenHandler=0). BadInstr capture still occurs on exception requests.

Decomposition:
- Shared package: CP0 regnum constants; ExcCode constants (OV=0x0C, RI=0x0A, SYS=0x08, BP=0x09); Status reset constant 32'h0000_FF01.
- Sub-modules: register (parameterised width and reset value; enable; async active-low reset) for user_status, EXL, EPC and BadInstr. mux3v (parameterised width; 2-bit select) for EPC source selection.

Test Plan:
- Reset 0 then release -> Status reads 0x0000FF01, Cause 0, EPC 0, takenHandler 0.
- syscall=1, curr_pc=0x1000, wr_data=0xDEADBEEF -> takenHandler=1 same cycle; after the edge: EPC=0x1004, Cause=0x20, Status bit1=1, BadInstr (sel1) reads 0xDEADBEEF.
- overflow and break_ both high -> ExcCode 0x0C, Cause reads 0x30.
- interrupt_source=0x04, IE=1, EXL=0, curr_pc=0x2000 -> takenHandler=1; EPC=0x2000; Cause=0x0400. With Status written to 0x0000FB01, the same interrupt is not taken.
- While EXL=1, assert syscall -> takenHandler=0, EPC unchanged. Then ERET -> EXL=0, ExcCode=0, BadInstr=0.
- MTC0 regnum14/sel0 with 0x1234 -> EPC=0x1234. MTC0 regnum12/sel0 with 0x2 -> Status reads 0x2 and blocks all handlers. Read regnum 5 -> 0.
